// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Registered ripple-carry adder built from WIDTH one-bit full-adder cells.
// Computes {cout, s} = a + b + cin as an exact (WIDTH+1)-bit unsigned result.
// With WIDTH=1 this is the classic single-bit full adder.
//
// Parameters
//   WIDTH    operand/sum width, legal range 1..64
//   REG_OUT  1: s/cout registered, 1-cycle latency, loaded only when in_valid=1
//            0: s/cout combinational from a/b/cin; only out_valid is registered
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   a          in   WIDTH  operand A (unsigned)
//   b          in   WIDTH  operand B (unsigned)
//   cin        in   1      carry into bit 0
//   in_valid   in   1      qualifies a/b/cin this cycle
//   s          out  WIDTH  sum
//   cout       out  1      carry out of the MSB cell
//   out_valid  out  1      s/cout hold a valid result
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
);

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             out_valid_reg;

    assign carry[0] = cin;

    // Explicit per-bit cells rather than a '+' so the structure matches the
    // bit-cell equations one-for-one.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign sum_comb[gi]  = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]   = (a[gi] & b[gi])
                                 | (a[gi] & carry[gi])
                                 | (b[gi] & carry[gi]);
        end
    endgenerate

    // out_valid is a registered copy of in_valid in both configurations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
        end
    end

    assign out_valid = out_valid_reg;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] s_reg;
            logic             cout_reg;

            // Result register loads only on valid input and otherwise holds,
            // so the last good result stays visible while out_valid is low.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_reg    <= '0;
                    cout_reg <= 1'b0;
                end else if (in_valid) begin
                    s_reg    <= sum_comb;
                    cout_reg <= carry[WIDTH];
                end
            end

            assign s    = s_reg;
            assign cout = cout_reg;
        end else begin : g_comb
            assign s    = sum_comb;
            assign cout = carry[WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Directed-vector bench for full_adder. Three instances:
//   u_dut1  WIDTH=1, REG_OUT=1  truth table, toggle pattern, hold, async reset
//   u_dut8  WIDTH=8, REG_OUT=1  carry boundaries and mixed patterns
//   u_dut4  WIDTH=4, REG_OUT=0  combinational path and registered out_valid
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, cin1, iv1;
    logic       s1, cout1, ov1;

    logic [7:0] a8, b8, s8;
    logic       cin8, iv8, cout8, ov8;

    logic [3:0] a4, b4, s4;
    logic       cin4, iv4, cout4, ov4;

    int checks;
    int errors;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .s(s1), .cout(cout1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .s(s8), .cout(cout8), .out_valid(ov8)
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .s(s4), .cout(cout4), .out_valid(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the bench has no open-ended waits, but guard anyway.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed truth table indexed by {a,b,cin}.
    logic [7:0] tt_s;
    logic [7:0] tt_c;
    logic [2:0] vec;

    initial begin
        checks = 0;
        errors = 0;
        tt_s   = 8'b1001_0110;   // bit v: s for {a,b,cin}=v
        tt_c   = 8'b1110_1000;   // bit v: cout for {a,b,cin}=v

        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
        a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;
        a4 = 0; b4 = 0; cin4 = 0; iv4 = 0;

        // ---- reset state ----
        #3;
        check_val("rst_s1",  s1,  0);
        check_val("rst_c1",  cout1, 0);
        check_val("rst_ov1", ov1, 0);
        check_val("rst_s8",  s8,  0);
        check_val("rst_ov8", ov8, 0);
        check_val("rst_ov4", ov4, 0);

        // ---- release with a valid pulse on the first live edge ----
        #9;   // t=12, between edges
        rst_n = 1'b1;
        a1 = 1; b1 = 0; cin1 = 1; iv1 = 1;
        step();
        check_val("rel_s1",  s1,  0);
        check_val("rel_c1",  cout1, 1);
        check_val("rel_ov1", ov1, 1);

        // ---- WIDTH=1 truth-table sweep ----
        for (int v = 0; v < 8; v++) begin
            vec = 3'(v);
            a1 = vec[2]; b1 = vec[1]; cin1 = vec[0]; iv1 = 1;
            step();
            check_val($sformatf("tt%0d_s", v),  s1,    tt_s[v]);
            check_val($sformatf("tt%0d_c", v),  cout1, tt_c[v]);
            check_val($sformatf("tt%0d_ov", v), ov1,   1);
        end

        // ---- toggle pattern: a /20ns, b /30ns, cin /50ns over 1000ns ----
        for (int k = 0; k < 100; k++) begin
            int t;
            logic [1:0] exp_sum;
            t = k * 10;
            a1   = ((t / 20) % 2) == 1;
            b1   = ((t / 30) % 2) == 1;
            cin1 = ((t / 50) % 2) == 1;
            iv1  = 1;
            exp_sum = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            step();
            check_val($sformatf("tog%0d_s", k), s1,    exp_sum[0]);
            check_val($sformatf("tog%0d_c", k), cout1, exp_sum[1]);
        end

        // ---- hold when in_valid=0 ----
        a1 = 1; b1 = 0; cin1 = 0; iv1 = 1;
        step();
        check_val("hold_pre_s",  s1,    1);
        check_val("hold_pre_c",  cout1, 0);
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 0;
        step();
        check_val("hold_s",  s1,    1);
        check_val("hold_c",  cout1, 0);
        check_val("hold_ov", ov1,   0);

        // ---- asynchronous reset mid-operation ----
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
        step();
        check_val("ar_pre_s", s1,    1);
        check_val("ar_pre_c", cout1, 1);
        a1 = 0; b1 = 1; cin1 = 0;   // in-flight input that must be discarded
        #3;
        rst_n = 1'b0;
        #1;
        check_val("ar_s",  s1,    0);
        check_val("ar_c",  cout1, 0);
        check_val("ar_ov", ov1,   0);
        step();                      // edge while held in reset
        check_val("ar_edge_s",  s1,  0);
        check_val("ar_edge_ov", ov1, 0);
        #2;
        rst_n = 1'b1;
        iv1 = 0;
        step();
        check_val("ar_idle_s",  s1,    0);
        check_val("ar_idle_c",  cout1, 0);
        check_val("ar_idle_ov", ov1,   0);
        a1 = 1; b1 = 0; cin1 = 1; iv1 = 1;
        step();
        check_val("ar_post_s",  s1,    0);
        check_val("ar_post_c",  cout1, 1);
        check_val("ar_post_ov", ov1,   1);
        iv1 = 0;

        // ---- WIDTH=8 vectors ----
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1; iv8 = 1;
        step();
        check_val("w8_ff00_s", s8,    8'h00);
        check_val("w8_ff00_c", cout8, 1);
        check_val("w8_ov",     ov8,   1);
        a8 = 8'h5A; b8 = 8'hA5; cin8 = 0;
        step();
        check_val("w8_5aa5_s", s8,    8'hFF);
        check_val("w8_5aa5_c", cout8, 0);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1;
        step();
        check_val("w8_ones_s", s8,    8'hFF);
        check_val("w8_ones_c", cout8, 1);
        a8 = 8'h00; b8 = 8'h00; cin8 = 0;
        step();
        check_val("w8_zero_s", s8,    8'h00);
        check_val("w8_zero_c", cout8, 0);
        a8 = 8'h3C; b8 = 8'h47; cin8 = 1;   // 0x3C+0x47+1 = 0x84
        step();
        check_val("w8_mix_s", s8,    8'h84);
        check_val("w8_mix_c", cout8, 0);
        iv8 = 0;
        a8 = 8'h01; b8 = 8'h01;
        step();
        check_val("w8_hold_s",  s8,  8'h84);
        check_val("w8_hold_ov", ov8, 0);

        // ---- WIDTH=4 combinational (REG_OUT=0) ----
        #2;                           // mid-cycle, no edge in between
        a4 = 4'h9; b4 = 4'h7; cin4 = 1;
        #1;
        check_val("w4_97_s",  s4,    4'h1);
        check_val("w4_97_c",  cout4, 1);
        check_val("w4_ov0",   ov4,   0);
        a4 = 4'h2; b4 = 4'h3; cin4 = 0;
        #1;
        check_val("w4_23_s",  s4,    4'h5);
        check_val("w4_23_c",  cout4, 0);
        iv4 = 1;
        step();
        check_val("w4_ov1",   ov4,   1);
        iv4 = 0;
        step();
        check_val("w4_ov_lo", ov4,   0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
